hilo_muldiv_ctrl: RTL

//  Sequencer for the MULT/MULTU/DIV/DIVU instructions of the mips16e core.
//  - Runs an iterative shift-add multiply or restoring divide, one bit per cycle.
//  - Drives data and load strobes for the external HI and LO load-enable registers.
//  - Stalls the pipeline while an operation is in flight; the pipeline can abort
//    an operation on a flush.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/hilo_muldiv_ctrl_if.sv | 31 +++
 rtl/muldiv_step.sv | 42 ++++
 rtl/hilo_muldiv_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer.
// Op and state encodings plus small op-decode helpers.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CALC  = 2'b01,
        S_FIX   = 2'b10,
        S_WRITE = 2'b11
    } state_e;

    typedef enum logic {
        M_MUL = 1'b0,
        M_DIV = 1'b1
    } mode_e;

    function automatic logic op_signed(op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic mode_e op_mode(op_e op);
        return ((op == OP_DIVU) || (op == OP_DIV)) ? M_DIV : M_MUL;
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Pipeline <-> muldiv sequencer bundle.
// master = pipeline side, slave = sequencer side.
interface hilo_muldiv_ctrl_if #(
    parameter int WORD_SIZE = 16
);
    logic                 start;
    logic [1:0]           op;
    logic [WORD_SIZE-1:0] src_a;
    logic [WORD_SIZE-1:0] src_b;
    logic                 abort;
    logic                 hilo_rd;
    logic                 busy;
    logic                 stall;
    logic                 done;
    logic                 hi_load;
    logic                 lo_load;
    logic [WORD_SIZE-1:0] hi_data;
    logic [WORD_SIZE-1:0] lo_data;

    modport master (
        output start, op, src_a, src_b, abort, hilo_rd,
        input  busy, stall, done, hi_load, lo_load,
        input  hi_data, lo_data
    );

    modport slave (
        input  start, op, src_a, src_b, abort, hilo_rd,
        output busy, stall, done, hi_load, lo_load,
        output hi_data, lo_data
    );
endinterface

// File: rtl/muldiv_step.sv
// One bit of shift-add multiply or restoring divide.
// acc = {hi, lo} for multiply, {remainder, dividend/quotient} for divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int W = 16
) (
    input  mode_e          mode,
    input  logic [2*W-1:0] acc,
    input  logic [W-1:0]   operand,
    output logic [2*W-1:0] acc_next,
    output logic           qbit
);
    logic [W:0]   sum;
    logic [W:0]   shifted;
    logic [W-1:0] diff;

    always_comb begin
        sum      = {1'b0, acc[2*W-1:W]} + {1'b0, operand};
        shifted  = {acc[2*W-1:W], acc[W-1]};
        // remainder < divisor always, so the true difference fits W bits
        diff     = shifted[W-1:0] - operand;
        acc_next = '0;
        qbit     = 1'b0;
        unique case (mode)
            M_MUL: begin
                qbit     = acc[0];
                acc_next = acc[0] ? {sum, acc[W-1:1]}
                                  : {1'b0, acc[2*W-1:1]};
            end
            M_DIV: begin
                qbit     = (shifted >= {1'b0, operand});
                acc_next = {qbit ? diff : shifted[W-1:0],
                            acc[W-2:0], 1'b0};
            end
            default: begin
                qbit     = 1'b0;
                acc_next = acc;
            end
        endcase
    end
endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer: one bit per cycle, then sign fix,
// then a single-cycle HI/LO write strobe.
module hilo_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input logic               clk,
    input logic               rst,
    hilo_muldiv_ctrl_if.slave bus
);
    localparam int W     = WORD_SIZE;
    localparam int CNT_W = $clog2(W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e         state;
    state_e         state_nx;
    mode_e          mode_q;
    logic           sign_a;
    logic           sign_b;
    logic [W-1:0]   opnd;
    logic [2*W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]   hi_q;
    logic [W-1:0]   lo_q;

    op_e            op_in;
    mode_e          mode_in;
    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic           div_zero;
    logic           issue;

    logic [2*W-1:0] step_acc;
    logic           step_q;

    logic [2*W-1:0] prod;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;
    logic [W-1:0]   fix_hi;
    logic [W-1:0]   fix_lo;

    assign op_in    = op_e'(bus.op);
    assign mode_in  = op_mode(op_in);
    assign a_neg    = op_signed(op_in) & bus.src_a[W-1];
    assign b_neg    = op_signed(op_in) & bus.src_b[W-1];
    assign a_mag    = a_neg ? -bus.src_a : bus.src_a;
    assign b_mag    = b_neg ? -bus.src_b : bus.src_b;
    assign div_zero = (mode_in == M_DIV) && (bus.src_b == '0);
    // abort wins over a same-cycle issue
    assign issue    = (state == S_IDLE) && bus.start && !bus.abort;

    muldiv_step #(
        .W(W)
    ) u_step (
        .mode    (mode_q),
        .acc     (acc),
        .operand (opnd),
        .acc_next(step_acc),
        .qbit    (step_q)
    );

    // sign flags are zero for unsigned ops, so no op check needed here
    always_comb begin
        prod   = (sign_a ^ sign_b) ? -acc : acc;
        quo    = (sign_a ^ sign_b) ? -acc[W-1:0] : acc[W-1:0];
        rem    = sign_a ? -acc[2*W-1:W] : acc[2*W-1:W];
        fix_hi = (mode_q == M_MUL) ? prod[2*W-1:W] : rem;
        fix_lo = (mode_q == M_MUL) ? prod[W-1:0]   : quo;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        bus.busy    = 1'b0;
        bus.stall   = 1'b0;
        bus.done    = 1'b0;
        bus.hi_load = 1'b0;
        bus.lo_load = 1'b0;
        bus.hi_data = hi_q;
        bus.lo_data = lo_q;

        unique case (state)
            S_IDLE: begin
                if (issue) begin
                    state_nx = div_zero ? S_WRITE : S_CALC;
                end
            end
            S_CALC: begin
                if (bus.abort) begin
                    state_nx = S_IDLE;
                end else if (cnt == '0) begin
                    state_nx = S_FIX;
                end
            end
            S_FIX: begin
                state_nx = bus.abort ? S_IDLE : S_WRITE;
            end
            S_WRITE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        bus.busy    = (state != S_IDLE);
        bus.stall   = bus.busy & (bus.hilo_rd | bus.start);
        bus.done    = (state == S_WRITE);
        bus.hi_load = (state == S_WRITE);
        bus.lo_load = (state == S_WRITE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= M_MUL;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            if (issue) begin
                mode_q <= mode_in;
                sign_a <= a_neg;
                sign_b <= b_neg;
                cnt    <= CNT_LAST;
                if (mode_in == M_MUL) begin
                    acc  <= {{W{1'b0}}, b_mag};
                    opnd <= a_mag;
                end else begin
                    acc  <= {{W{1'b0}}, a_mag};
                    opnd <= b_mag;
                end
                if (div_zero) begin
                    hi_q <= bus.src_a;
                    lo_q <= '1;
                end
            end
            if (state == S_CALC) begin
                acc <= {step_acc[2*W-1:1],
                        (mode_q == M_DIV) ? step_q : step_acc[0]};
                cnt <= cnt - CNT_ONE;
            end
            if ((state == S_FIX) && !bus.abort) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end
        end
    end
endmodule
